imem_loader: RTL and testbench

- Write-side counterpart to the IMEM read path: accepts a byte stream and assembles 32-bit words, little-endian.
- Writes each word into instruction memory at sequential word addresses, starting at 0.
- Holds the core stalled while loading; the core's fetch path then reads the image through the existing addr/data port.
- Sits between the boot/debug byte source and the IMEM write port.

---
 rtl/imem_pkg.sv | 6 +
 rtl/imem_loader_byte_packer.sv | 43 ++++
 rtl/imem_loader.sv | 121 ++++++++++++
 tb/tb_imem_loader.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared IMEM constants, word type and loader state encoding
package imem_pkg;
    localparam int IMEM_DEPTH = 1024;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} loader_state_t;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: assembles four bytes into a little-endian 32-bit word
//   clr_i       - clears the byte counter and lanes
//   push_i      - byte_i is consumed this cycle
//   byte_i      - incoming byte, placed in lane k (k = byte counter)
//   word_o      - current lanes with byte_i already placed in lane k,
//                 so it is the complete word on the cycle word_full_o is high
//   word_full_o - this push completes the word (k == 3)
module byte_packer
    import imem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       push_i,
    input  logic [7:0] byte_i,
    output word_t      word_o,
    output logic       word_full_o
);
    logic [1:0] k_q;
    word_t      lanes_q;
    word_t      lanes_d;

    always_comb begin
        lanes_d = lanes_q;
        lanes_d[{k_q, 3'b000} +: 8] = byte_i;
    end

    assign word_o      = lanes_d;
    assign word_full_o = push_i && (k_q == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q     <= '0;
            lanes_q <= '0;
        end else if (clr_i) begin
            k_q     <= '0;
            lanes_q <= '0;
        end else if (push_i) begin
            k_q     <= k_q + 2'd1;
            lanes_q <= lanes_d;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a byte stream into IMEM as little-endian words, stalling the core
//   start_i/load_len_i      - begin a load of load_len_i words (accepted in IDLE or DONE)
//   in_valid_i/in_data_i    - byte source; transfer when in_valid_i && in_ready_o
//   imem_we_o/waddr/wdata   - one-cycle IMEM write per assembled word
//   busy_o/cpu_stall_o      - high while collecting or writing
//   done_o/err_o            - sticky status, cleared by the next accepted start
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [AW-1:0] load_len_i,
    input  logic          in_valid_i,
    input  logic [7:0]    in_data_i,
    output logic          in_ready_o,
    output logic          imem_we_o,
    output logic [AW-1:0] imem_waddr_o,
    output word_t         imem_wdata_o,
    output logic          busy_o,
    output logic          cpu_stall_o,
    output logic          done_o,
    output logic          err_o
);
    loader_state_t state_q;
    logic [AW-1:0] len_q;
    logic [AW-1:0] word_cnt_q;
    logic          in_ready_q;
    logic          imem_we_q;
    logic [AW-1:0] imem_waddr_q;
    word_t         imem_wdata_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic          accept;
    logic          push;
    logic          word_full;
    word_t         word;
    logic [AW-1:0] word_cnt_inc;

    assign accept       = start_i && (state_q == IDLE || state_q == DONE);
    assign push         = in_valid_i && in_ready_q;
    assign word_cnt_inc = word_cnt_q + AW'(1);

    byte_packer u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (accept),
        .push_i      (push),
        .byte_i      (in_data_i),
        .word_o      (word),
        .word_full_o (word_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            len_q        <= '0;
            word_cnt_q   <= '0;
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_waddr_q <= '0;
            imem_wdata_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            imem_we_q <= 1'b0;
            case (state_q)
                IDLE, DONE: if (accept) begin
                    len_q      <= load_len_i;
                    word_cnt_q <= '0;
                    done_q     <= 1'b0;
                    err_q      <= 1'b0;
                    if (load_len_i == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else if (load_len_i > AW'(DEPTH)) begin
                        state_q <= DONE;
                        err_q   <= 1'b1;
                    end else begin
                        state_q    <= COLLECT;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                COLLECT: if (word_full) begin
                    state_q      <= WRITE;
                    in_ready_q   <= 1'b0;
                    imem_we_q    <= 1'b1;
                    imem_waddr_q <= word_cnt_q;
                    imem_wdata_q <= word;
                end
                WRITE: begin
                    word_cnt_q <= word_cnt_inc;
                    if (word_cnt_inc == len_q) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q    <= COLLECT;
                        in_ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready_o   = in_ready_q;
    assign imem_we_o    = imem_we_q;
    assign imem_waddr_o = imem_waddr_q;
    assign imem_wdata_o = imem_wdata_q;
    assign busy_o       = busy_q;
    assign cpu_stall_o  = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed scoreboard bench for imem_loader
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] load_len = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready, imem_we, busy, cpu_stall, done, err;
    logic [31:0] imem_waddr, imem_wdata;

    int checks = 0;
    int failures = 0;
    int writes = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    imem_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start),
        .load_len_i   (load_len),
        .in_valid_i   (in_valid),
        .in_data_i    (in_data),
        .in_ready_o   (in_ready),
        .imem_we_o    (imem_we),
        .imem_waddr_o (imem_waddr),
        .imem_wdata_o (imem_wdata),
        .busy_o       (busy),
        .cpu_stall_o  (cpu_stall),
        .done_o       (done),
        .err_o        (err)
    );

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && imem_we === 1'b1) begin
            writes++;
            chk("ready_low_in_write", {71'd0, in_ready}, 72'd0);
            if (sb.size() == 0) begin
                chk("unexpected_write", {8'd0, imem_waddr, imem_wdata}, 72'hFF_FFFF_FFFF_FFFF_FFFF);
            end else begin
                chk("write_addr_data", {8'd0, imem_waddr, imem_wdata}, {8'd0, sb.pop_front()});
            end
        end
    end

    task automatic pulse_start(input logic [31:0] len);
        @(negedge clk);
        start = 1'b1;
        load_len = len;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit rnd);
        int n = 0;
        forever begin
            @(negedge clk);
            in_data = b;
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (in_valid && in_ready) break;
            if (++n > 200) begin
                chk("send_timeout", 72'd1, 72'd0);
                break;
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit rnd);
        for (int i = 0; i < 4; i++) send(w[8*i +: 8], rnd);
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (!(done || err)) begin
            if (++n > 50) begin
                chk("done_timeout", 72'd1, 72'd0);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk(tag, {64'd0, in_ready, imem_we, busy, cpu_stall, done, err, 2'b00}, 72'd0);
        chk({tag, "_bus"}, {8'd0, imem_waddr, imem_wdata}, 72'd0);
    endtask

    initial begin
        int w0;
        #2 check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // two-word load at full rate
        w0 = writes;
        sb.push_back({32'd0, 32'h0000_0013});
        sb.push_back({32'd1, 32'h0010_0093});
        pulse_start(2);
        chk("busy_after_start", {70'd0, busy, cpu_stall}, 72'd3);
        send_word(32'h0000_0013, 1'b0);
        send_word(32'h0010_0093, 1'b0);
        wait_done();
        chk("full_rate_writes", 72'(writes - w0), 72'd2);
        chk("full_rate_status", {68'd0, done, err, busy, cpu_stall}, {68'd0, 4'b1000});
        chk("sb_empty_1", 72'(sb.size()), 72'd0);

        // same load with in_valid toggling
        w0 = writes;
        sb.push_back({32'd0, 32'h0000_0013});
        sb.push_back({32'd1, 32'h0010_0093});
        pulse_start(2);
        send_word(32'h0000_0013, 1'b1);
        send_word(32'h0010_0093, 1'b1);
        wait_done();
        chk("rand_valid_writes", 72'(writes - w0), 72'd2);
        chk("rand_valid_done", {71'd0, done}, 72'd1);
        in_valid = 1'b1;
        in_data = 8'h55;
        @(negedge clk);
        chk("no_accept_after_done", {71'd0, in_ready}, 72'd0);
        in_valid = 1'b0;

        // zero-length and oversize loads
        w0 = writes;
        pulse_start(0);
        chk("len0_status", {68'd0, done, err, busy, in_ready}, {68'd0, 4'b1000});
        pulse_start(1025);
        chk("oversize_status", {68'd0, done, err, busy, in_ready}, {68'd0, 4'b0100});
        repeat (3) @(negedge clk);
        chk("len0_oversize_no_write", 72'(writes - w0), 72'd0);

        // start pulsed mid-load is ignored
        w0 = writes;
        for (int i = 0; i < 3; i++) sb.push_back({32'(i), 32'hA0B0_C000 + 32'(i)});
        pulse_start(3);
        send_word(32'hA0B0_C000, 1'b0);
        send(8'h01, 1'b0);
        pulse_start(7);
        chk("mid_start_busy", {71'd0, busy}, 72'd1);
        send(8'hC0, 1'b0);
        send(8'hB0, 1'b0);
        send(8'hA0, 1'b0);
        send_word(32'hA0B0_C002, 1'b0);
        wait_done();
        chk("mid_start_writes", 72'(writes - w0), 72'd3);
        chk("sb_empty_2", 72'(sb.size()), 72'd0);

        // reset after two bytes of a word
        w0 = writes;
        pulse_start(1);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        #3 rst_n = 1'b0;
        #1 check_idle_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset_no_write", 72'(writes - w0), 72'd0);
        sb.push_back({32'd0, 32'h0403_0201});
        pulse_start(1);
        send_word(32'h0403_0201, 1'b0);
        wait_done();
        chk("reload_writes", 72'(writes - w0), 72'd1);

        // restart from DONE
        w0 = writes;
        sb.push_back({32'd0, 32'hDEAD_BEEF});
        pulse_start(1);
        chk("restart_done_clear", {70'd0, done, busy}, 72'd1);
        send_word(32'hDEAD_BEEF, 1'b0);
        wait_done();
        chk("restart_writes", 72'(writes - w0), 72'd1);
        chk("restart_done", {70'd0, done, cpu_stall}, 72'd2);
        chk("sb_empty_3", 72'(sb.size()), 72'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
